// File: rtl/pll_acq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pll_acq_ctrl
// Brief   : PLL acquisition sequencer - frequency load, gear-shifted loop
//           bandwidth narrowing, windowed lock detection and loss recovery.
// Rev     : 1.0  initial release
// ============================================================================
module pll_acq_ctrl #(
    parameter int PHASE_BITS    = 32,
    parameter int LG_WIDE       = 2,
    parameter int LG_NARROW     = 10,
    parameter int WINDOW        = 1024,
    parameter int LOCK_THRESH   = 16,
    parameter int UNLOCK_THRESH = 128,
    parameter int TIMEOUT_WIN   = 64
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  swiptAlive,
    input  logic                  start,
    input  logic [PHASE_BITS-2:0] init_freq,
    input  logic [1:0]            pll_error,
    output logic                  load_freq,
    output logic [PHASE_BITS-2:0] freq,
    output logic [4:0]            lgcoefficient,
    output logic                  pll_run,
    output logic                  locked,
    output logic                  lock_lost,
    output logic                  busy
);

    localparam int c_win_w = $clog2(WINDOW);
    localparam int c_err_w = c_win_w + 1;
    localparam int c_to_w  = $clog2(TIMEOUT_WIN + 1);

    localparam logic [4:0]         c_lg_wide   = 5'(LG_WIDE);
    localparam logic [4:0]         c_lg_narrow = 5'(LG_NARROW);
    localparam logic [c_win_w-1:0] c_win_last  = (c_win_w)'(WINDOW - 1);
    localparam logic [c_win_w-1:0] c_win_one   = (c_win_w)'(1);
    localparam logic [c_err_w-1:0] c_err_one   = (c_err_w)'(1);
    localparam logic [c_to_w-1:0]  c_to_one    = (c_to_w)'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_ACQUIRE = 2'd2,
        S_LOCKED  = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [PHASE_BITS-2:0] r_freq,  w_freq_nxt;
    logic [4:0]            r_lg,    w_lg_nxt;
    logic [c_win_w-1:0]    r_win,   w_win_nxt;
    logic [c_err_w-1:0]    r_err,   w_err_nxt;
    logic [c_to_w-1:0]     r_to,    w_to_nxt;
    logic                  r_lost,  w_lost_nxt;

    logic                  w_err_hit;
    logic                  w_win_end;
    logic [31:0]           w_total;
    logic [31:0]           w_to_inc;

    assign w_err_hit = (pll_error != 2'b00);
    assign w_win_end = (r_win == c_win_last);
    // The closing sample of a window is folded in here rather than registered first.
    assign w_total   = 32'(r_err) + 32'(w_err_hit);
    assign w_to_inc  = 32'(r_to) + 32'd1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_freq  <= '0;
            r_lg    <= c_lg_wide;
            r_win   <= '0;
            r_err   <= '0;
            r_to    <= '0;
            r_lost  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_freq  <= w_freq_nxt;
            r_lg    <= w_lg_nxt;
            r_win   <= w_win_nxt;
            r_err   <= w_err_nxt;
            r_to    <= w_to_nxt;
            r_lost  <= w_lost_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_freq_nxt  = r_freq;
        w_lg_nxt    = r_lg;
        w_win_nxt   = r_win;
        w_err_nxt   = r_err;
        w_to_nxt    = r_to;
        w_lost_nxt  = 1'b0;

        // Link loss overrides everything, including a coincident window decision.
        if (!swiptAlive) begin
            w_state_nxt = S_IDLE;
            w_lg_nxt    = c_lg_wide;
            w_win_nxt   = '0;
            w_err_nxt   = '0;
            w_to_nxt    = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_freq_nxt  = init_freq;
                        w_state_nxt = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_lg_nxt    = c_lg_wide;
                    w_win_nxt   = '0;
                    w_err_nxt   = '0;
                    w_to_nxt    = '0;
                    w_state_nxt = S_ACQUIRE;
                end
                S_ACQUIRE, S_LOCKED: begin
                    w_win_nxt = r_win + c_win_one;
                    if (w_win_end) begin
                        w_err_nxt = '0;
                        if (r_state == S_ACQUIRE) begin
                            if (w_total <= 32'(LOCK_THRESH)) begin
                                w_to_nxt = '0;
                                if (r_lg < c_lg_narrow) begin
                                    w_lg_nxt = r_lg + 5'd1;
                                end else begin
                                    w_state_nxt = S_LOCKED;
                                end
                            end else begin
                                w_lg_nxt = c_lg_wide;
                                if (w_to_inc >= 32'(TIMEOUT_WIN)) begin
                                    w_to_nxt    = '0;
                                    w_state_nxt = S_LOAD;
                                end else begin
                                    w_to_nxt = r_to + c_to_one;
                                end
                            end
                        end else if (w_total > 32'(UNLOCK_THRESH)) begin
                            // Re-acquire from the tracked frequency; no reload.
                            w_lost_nxt  = 1'b1;
                            w_lg_nxt    = c_lg_wide;
                            w_to_nxt    = '0;
                            w_state_nxt = S_ACQUIRE;
                        end
                    end else if (w_err_hit && (r_err != '1)) begin
                        w_err_nxt = r_err + c_err_one;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign load_freq     = (r_state == S_LOAD);
    assign freq          = r_freq;
    assign lgcoefficient = r_lg;
    assign pll_run       = (r_state == S_ACQUIRE) || (r_state == S_LOCKED);
    assign locked        = (r_state == S_LOCKED);
    assign lock_lost     = r_lost;
    assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pll_acq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pll_acq_ctrl
// Brief   : Directed plus randomized bench for pll_acq_ctrl against a
//           behavioural window/lock model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pll_acq_ctrl;

    localparam int PB  = 32;
    localparam int LW  = 4;
    localparam int LN  = 6;
    localparam int WIN = 16;
    localparam int LT  = 2;
    localparam int UT  = 8;
    localparam int TW  = 3;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_ACQ  = 2;
    localparam int M_LOCK = 3;

    logic          clk;
    logic          nrst;
    logic          swiptAlive;
    logic          start;
    logic [PB-2:0] init_freq;
    logic [1:0]    pll_error;
    logic          load_freq;
    logic [PB-2:0] freq;
    logic [4:0]    lgcoefficient;
    logic          pll_run;
    logic          locked;
    logic          lock_lost;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model
    int            m_mode;
    logic [PB-2:0] m_freq;
    int            m_lg;
    int            m_pos;
    int            m_errs;
    int            m_bad;
    bit            m_lost;
    bit            m_valid = 1'b0;

    pll_acq_ctrl #(
        .PHASE_BITS   (PB),
        .LG_WIDE      (LW),
        .LG_NARROW    (LN),
        .WINDOW       (WIN),
        .LOCK_THRESH  (LT),
        .UNLOCK_THRESH(UT),
        .TIMEOUT_WIN  (TW)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .swiptAlive   (swiptAlive),
        .start        (start),
        .init_freq    (init_freq),
        .pll_error    (pll_error),
        .load_freq    (load_freq),
        .freq         (freq),
        .lgcoefficient(lgcoefficient),
        .pll_run      (pll_run),
        .locked       (locked),
        .lock_lost    (lock_lost),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_freq = '0;
        m_lg   = LW;
        m_pos  = 0;
        m_errs = 0;
        m_bad  = 0;
        m_lost = 1'b0;
    endtask

    // One clock edge of the model, using the inputs the DUT just sampled.
    task automatic model_clock();
        int total;
        if (!nrst) return;
        m_lost = 1'b0;
        if (!swiptAlive) begin
            m_mode = M_IDLE; m_lg = LW; m_pos = 0; m_errs = 0; m_bad = 0;
            return;
        end
        if (m_mode == M_IDLE) begin
            if (start) begin
                m_freq = init_freq;
                m_mode = M_LOAD;
            end
        end else if (m_mode == M_LOAD) begin
            m_mode = M_ACQ; m_lg = LW; m_pos = 0; m_errs = 0; m_bad = 0;
        end else if (m_pos == WIN - 1) begin
            total  = m_errs + ((pll_error != 2'b00) ? 1 : 0);
            m_errs = 0;
            m_pos  = 0;
            if (m_mode == M_ACQ) begin
                if (total <= LT) begin
                    m_bad = 0;
                    if (m_lg < LN) m_lg++;
                    else m_mode = M_LOCK;
                end else begin
                    m_lg = LW;
                    m_bad++;
                    if (m_bad == TW) begin
                        m_bad  = 0;
                        m_mode = M_LOAD;
                    end
                end
            end else if (total > UT) begin
                m_lost = 1'b1;
                m_lg   = LW;
                m_bad  = 0;
                m_mode = M_ACQ;
            end
        end else begin
            m_pos++;
            if (pll_error != 2'b00) m_errs++;
        end
    endtask

    task automatic compare_all();
        chk("load_freq", 32'(load_freq), 32'(m_mode == M_LOAD));
        chk("freq", 32'(freq), 32'(m_freq));
        chk("lgcoefficient", 32'(lgcoefficient), 32'(m_lg));
        chk("pll_run", 32'(pll_run), 32'((m_mode == M_ACQ) || (m_mode == M_LOCK)));
        chk("locked", 32'(locked), 32'(m_mode == M_LOCK));
        chk("lock_lost", 32'(lock_lost), 32'(m_lost));
        chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
    endtask

    always @(negedge clk) begin
        if (m_valid) compare_all();
    end

    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic win(input int nerr, input logic [1:0] code);
        for (int i = 0; i < WIN; i++) begin
            pll_error = (i < nerr) ? code : 2'b00;
            tick();
        end
        pll_error = 2'b00;
    endtask

    task automatic chk_reset_literals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_run"}, 32'(pll_run), 32'd0);
        chk({tag, "_load"}, 32'(load_freq), 32'd0);
        chk({tag, "_lost"}, 32'(lock_lost), 32'd0);
        chk({tag, "_lg"}, 32'(lgcoefficient), 32'd4);
        chk({tag, "_freq"}, 32'(freq), 32'd0);
    endtask

    initial begin
        int rate;
        nrst = 1'b0; swiptAlive = 1'b0; start = 1'b0;
        init_freq = '0; pll_error = 2'b00;
        model_reset();
        m_valid = 1'b1;
        repeat (3) tick();
        chk_reset_literals("reset");
        nrst = 1'b1;
        swiptAlive = 1'b1;

        // Clean acquisition from 0x1000
        start = 1'b1; init_freq = 31'h1000;
        tick();
        start = 1'b0;
        chk("acq_load_pulse", 32'(load_freq), 32'd1);
        chk("acq_load_value", 32'(freq), 32'h1000);
        tick();
        chk("acq_load_one_cycle", 32'(load_freq), 32'd0);
        repeat (WIN - 1) tick();
        chk("acq_lg_before_end", 32'(lgcoefficient), 32'd4);
        tick();
        chk("acq_lg_win1", 32'(lgcoefficient), 32'd5);
        win(0, 2'b00);
        chk("acq_lg_win2", 32'(lgcoefficient), 32'd6);
        chk("acq_not_locked_yet", 32'(locked), 32'd0);
        win(0, 2'b00);
        chk("acq_locked_win3", 32'(locked), 32'd1);

        // Loss of lock at 9 errors, then hold at 8 errors
        win(9, 2'b01);
        chk("unlock_pulse", 32'(lock_lost), 32'd1);
        chk("unlock_locked", 32'(locked), 32'd0);
        chk("unlock_lg", 32'(lgcoefficient), 32'd4);
        chk("unlock_no_reload", 32'(load_freq), 32'd0);
        repeat (3) win(0, 2'b00);
        chk("relock", 32'(locked), 32'd1);
        win(8, 2'b11);
        chk("hold_8_locked", 32'(locked), 32'd1);
        chk("hold_8_no_lost", 32'(lock_lost), 32'd0);

        // Bad window during ACQUIRE at lg 5
        win(12, 2'b01);
        win(0, 2'b00);
        chk("acq_lg5", 32'(lgcoefficient), 32'd5);
        win(3, 2'b01);
        chk("bad3_lg", 32'(lgcoefficient), 32'd4);
        chk("bad3_locked", 32'(locked), 32'd0);

        // Start ignored outside IDLE; then timeout reload
        start = 1'b1; init_freq = 31'h7777;
        win(0, 2'b00);
        start = 1'b0;
        chk("start_ignored", 32'(freq), 32'h1000);
        repeat (3) win(WIN, 2'b01);
        chk("timeout_reload", 32'(load_freq), 32'd1);
        chk("timeout_freq", 32'(freq), 32'h1000);
        tick();
        repeat (3) win(0, 2'b00);
        chk("lock_after_reload", 32'(locked), 32'd1);

        // Link drop coincident with a bad window end
        pll_error = 2'b11;
        repeat (WIN - 1) tick();
        swiptAlive = 1'b0;
        tick();
        pll_error = 2'b00;
        chk("drop_busy", 32'(busy), 32'd0);
        chk("drop_locked", 32'(locked), 32'd0);
        chk("drop_no_lost", 32'(lock_lost), 32'd0);
        chk("drop_lg", 32'(lgcoefficient), 32'd4);
        chk("drop_freq_held", 32'(freq), 32'h1000);
        tick();
        swiptAlive = 1'b1; start = 1'b1; init_freq = 31'h2345;
        tick();
        start = 1'b0;
        chk("restart_load", 32'(load_freq), 32'd1);
        chk("restart_freq", 32'(freq), 32'h2345);

        // Asynchronous reset mid-window
        repeat (5) tick();
        #2 nrst = 1'b0;
        #1 model_reset();
        chk_reset_literals("async_rst");
        tick();
        nrst = 1'b1;

        // Randomized traffic with varying error density
        rate = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 100 == 0) begin
                case ($urandom_range(0, 4))
                    0, 1:    rate = 0;
                    2:       rate = 5;
                    3:       rate = 35;
                    default: rate = 100;
                endcase
            end
            swiptAlive = ($urandom_range(0, 299) != 0);
            start      = ($urandom_range(0, 39) == 0);
            init_freq  = 31'($urandom);
            if (int'($urandom_range(0, 99)) < rate)
                pll_error = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
            else
                pll_error = 2'b00;
            tick();
            if ($urandom_range(0, 999) == 0) begin
                #2 nrst = 1'b0;
                #1 model_reset();
                chk("rand_rst_busy", 32'(busy), 32'd0);
                tick();
                nrst = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pll_acq_ctrl.md
PLL_ACQ_CTRL -- requirements
Module: pll_acq_ctrl

Interface
REQ-001 SHALL have parameter PHASE_BITS, default 32, meaning the PLL phase accumulator width; freq is PHASE_BITS-1 bits.
REQ-002 SHALL have parameter LG_WIDE, default 2, meaning the lgcoefficient used at acquisition start (widest loop bandwidth).
REQ-003 SHALL have parameter LG_NARROW, default 10, meaning the final tracking lgcoefficient; LG_WIDE <= LG_NARROW <= 31.
REQ-004 SHALL have parameter WINDOW, default 1024, meaning the observation window length in cycles (power of two, >= 4).
REQ-005 SHALL have parameter LOCK_THRESH, default 16, meaning the max error cycles per window that still counts as a good window.
REQ-006 SHALL have parameter UNLOCK_THRESH, default 128, meaning the error cycles per window above which lock is declared lost.
REQ-007 SHALL have parameter TIMEOUT_WIN, default 64, meaning the max consecutive bad windows in ACQUIRE before frequency reload.
REQ-008 SHALL have ports clk (input, 1, system clock; all state on rising edge) and nrst (input, 1, asynchronous active-low reset).
REQ-009 SHALL have port swiptAlive (input, 1, power-link alive; low forces IDLE).
REQ-010 SHALL have port start (input, 1, single-cycle request to begin acquisition).
REQ-011 SHALL have port init_freq (input, PHASE_BITS-1, nominal phase step, captured when start is accepted).
REQ-012 SHALL have port pll_error (input, 2, PLL error code: 00 none, 01 lag, 11 lead).
REQ-013 SHALL have ports load_freq (output, 1, one-cycle PLL frequency load strobe) and freq (output, PHASE_BITS-1, value to load).
REQ-014 SHALL have ports lgcoefficient (output, 5, PLL loop gain shift) and pll_run (output, 1, PLL loop enable).
REQ-015 SHALL have ports locked (output, 1, lock status), lock_lost (output, 1, one-cycle pulse on loss of lock) and busy (output, 1, high in any state except IDLE).

Function
REQ-016 SHALL implement states IDLE, LOAD, ACQUIRE and LOCKED.
REQ-017 IDLE: start=1 and swiptAlive=1 -> capture init_freq into freq, go to LOAD; start while not in IDLE is ignored.
REQ-018 LOAD: load_freq=1 for exactly one cycle, lgcoefficient=LG_WIDE; clear window counter, error counter and timeout counter; next state ACQUIRE.
REQ-019 pll_run SHALL be 1 only in ACQUIRE and LOCKED; load_freq SHALL be 1 only in LOAD.
REQ-020 Window: counter counts 0..WINDOW-1 in ACQUIRE/LOCKED and wraps; each cycle with pll_error!=00 increments a saturating error count (width clog2(WINDOW)+1).
REQ-021 Window end (counter = WINDOW-1): evaluate total = error count + current sample; error count restarts at 0 next cycle.
REQ-022 ACQUIRE good window (total <= LOCK_THRESH), lgcoefficient < LG_NARROW: lgcoefficient += 1 next cycle; timeout counter clears.
REQ-023 ACQUIRE good window, lgcoefficient = LG_NARROW: go to LOCKED; locked=1 from the next cycle.
REQ-024 ACQUIRE bad window: lgcoefficient returns to LG_WIDE; timeout counter += 1; on reaching TIMEOUT_WIN, go to LOAD (reload captured freq).
REQ-025 LOCKED bad window (total > UNLOCK_THRESH): lock_lost=1 for one cycle, locked=0, lgcoefficient=LG_WIDE, go to ACQUIRE without reload (PLL keeps its tracked frequency).
REQ-026 LOCKED with total <= UNLOCK_THRESH: remain LOCKED; lgcoefficient stays LG_NARROW.
REQ-027 swiptAlive=0 in any state -> IDLE next cycle; locked=0, pll_run=0, lgcoefficient=LG_WIDE, counters cleared, lock_lost not pulsed; freq is held.
REQ-028 swiptAlive=0 and a window end in the same cycle: swiptAlive has priority and no window decision is applied.
REQ-029 freq SHALL change only on start acceptance in IDLE.

Reset
REQ-030 nrst=0 SHALL asynchronously force IDLE, freq=0, lgcoefficient=LG_WIDE, load_freq=0, pll_run=0, locked=0, lock_lost=0, busy=0, and all counters to 0.
REQ-031 Reset mid-acquisition or while LOCKED SHALL abort without any lock_lost pulse; after release, the block waits for a new start.

Verification (WINDOW=16, LG_WIDE=4, LG_NARROW=6, LOCK_THRESH=2, UNLOCK_THRESH=8, TIMEOUT_WIN=3)
REQ-032 start with init_freq=0x1000, pll_error=00 -> load_freq pulses 1 cycle with freq=0x1000; lgcoefficient 4 -> 5 -> 6 at successive window ends; locked=1 after the third window.
REQ-033 ACQUIRE at lg=5, window with 3 error cycles -> lgcoefficient=4, timeout count=1, locked=0.
REQ-034 error every cycle in ACQUIRE -> after 3 windows, a second load_freq pulse with freq=0x1000; timeout counter=0.
REQ-035 LOCKED, window with 9 error cycles -> lock_lost 1-cycle pulse, locked=0, lgcoefficient=4, no load_freq; window with 8 error cycles -> stays LOCKED.
REQ-036 swiptAlive low during LOCKED, coincident with a window end -> IDLE, locked=0, no lock_lost; start then reacquires.
REQ-037 nrst asserted asynchronously mid-window -> all outputs reach reset values before the next clock edge.
